// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Multi-wide front-end fetch stage. Owns the PC, keeps up to
//            MAX_INFLIGHT I-cache group requests outstanding, buffers returned
//            instructions in a per-instruction queue and hands up to
//            FETCH_WIDTH of them per cycle to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                FETCH_WIDTH  = 2,
    parameter int                IQ_DEPTH     = 8,
    parameter int                MAX_INFLIGHT = 2,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_val,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          icache_req_val,
    input  logic                          icache_req_rdy,
    output logic [ADDR_W-1:0]             icache_req_addr,
    input  logic                          icache_resp_val,
    input  logic [FETCH_WIDTH*32-1:0]     icache_resp_data,
    input  logic                          dec_rdy,
    output logic [FETCH_WIDTH-1:0]        dec_val,
    output logic [FETCH_WIDTH*32-1:0]     dec_inst,
    output logic [FETCH_WIDTH*ADDR_W-1:0] dec_pc
);

    localparam int c_grp_bytes = FETCH_WIDTH * 4;
    localparam int c_off_w     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int c_ptr_w     = $clog2(IQ_DEPTH);
    localparam int c_cnt_w     = c_ptr_w + 1;
    localparam int c_inf_w     = $clog2(MAX_INFLIGHT + 1);
    localparam int c_ofp_w     = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    localparam logic [ADDR_W-1:0]  c_align_mask = ~ADDR_W'(c_grp_bytes - 1);
    localparam logic [c_off_w-1:0] c_off_mask   = c_off_w'(FETCH_WIDTH - 1);
    localparam logic [c_off_w-1:0] c_reset_off  = c_off_w'(RESET_PC >> 2) & c_off_mask;
    localparam logic [c_cnt_w-1:0] c_fw_cnt     = c_cnt_w'(FETCH_WIDTH);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_off_w-1:0] r_start_off;
    logic [c_inf_w-1:0] r_inflight;
    logic [c_inf_w-1:0] r_drop;

    logic [ADDR_W-1:0]  r_of_pc  [MAX_INFLIGHT];
    logic [c_off_w-1:0] r_of_off [MAX_INFLIGHT];
    logic [c_ofp_w-1:0] r_of_rd;
    logic [c_ofp_w-1:0] r_of_wr;

    logic [31:0]        r_iq_inst [IQ_DEPTH];
    logic [ADDR_W-1:0]  r_iq_pc   [IQ_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic               w_credit_ok;
    logic               w_req_val;
    logic               w_req_fire;
    logic               w_resp;
    logic               w_enq;
    logic               w_deq;
    logic [c_off_w-1:0] w_resp_off;
    logic [ADDR_W-1:0]  w_resp_pc;
    logic [c_off_w-1:0] w_redir_off;
    logic [c_cnt_w-1:0] w_enq_n;
    logic [c_cnt_w-1:0] w_deq_n;
    logic [c_ofp_w-1:0] w_of_rd_nxt;
    logic [c_ofp_w-1:0] w_of_wr_nxt;
    logic [c_ptr_w-1:0] w_wr_idx [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] w_wr_en;

    // Every outstanding request reserves a full group of queue space, so any
    // response that comes back is guaranteed to fit.
    assign w_credit_ok = (32'(r_count) + 32'(FETCH_WIDTH) * 32'(r_inflight) + 32'(FETCH_WIDTH))
                         <= 32'(IQ_DEPTH);
    assign w_req_val   = rst_n && !redirect_val && (r_inflight < c_inf_w'(MAX_INFLIGHT)) && w_credit_ok;
    assign w_req_fire  = w_req_val && icache_req_rdy;

    assign icache_req_val  = w_req_val;
    assign icache_req_addr = r_pc;

    assign w_resp      = icache_resp_val && (r_inflight != '0);
    assign w_resp_off  = r_of_off[r_of_rd];
    assign w_resp_pc   = r_of_pc[r_of_rd];
    assign w_enq       = w_resp && (r_drop == '0) && !redirect_val;
    assign w_enq_n     = c_fw_cnt - c_cnt_w'(w_resp_off);
    assign w_deq_n     = (r_count < c_fw_cnt) ? r_count : c_fw_cnt;
    assign w_deq       = dec_rdy && !redirect_val;
    assign w_redir_off = c_off_w'(redirect_pc >> 2) & c_off_mask;

    assign w_of_rd_nxt = (r_of_rd == c_ofp_w'(MAX_INFLIGHT - 1)) ? '0 : r_of_rd + c_ofp_w'(1);
    assign w_of_wr_nxt = (r_of_wr == c_ofp_w'(MAX_INFLIGHT - 1)) ? '0 : r_of_wr + c_ofp_w'(1);

    generate
        for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
            // Slot k of a group lands (k - start offset) entries past the tail.
            assign w_wr_idx[k] = r_tail + c_ptr_w'(k) - c_ptr_w'(w_resp_off);
            assign w_wr_en[k]  = w_enq && (c_off_w'(k) >= w_resp_off);

            assign dec_val[k]                   = !redirect_val && (c_cnt_w'(k) < r_count);
            assign dec_inst[32*k +: 32]         = r_iq_inst[r_head + c_ptr_w'(k)];
            assign dec_pc[ADDR_W*k +: ADDR_W]   = r_iq_pc[r_head + c_ptr_w'(k)];
        end
    endgenerate

    // Data storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (w_wr_en[k]) begin
                r_iq_inst[w_wr_idx[k]] <= icache_resp_data[32*k +: 32];
                r_iq_pc[w_wr_idx[k]]   <= w_resp_pc + ADDR_W'(4 * k);
            end
        end
        if (w_req_fire) begin
            r_of_pc[r_of_wr]  <= r_pc;
            r_of_off[r_of_wr] <= r_start_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC & c_align_mask;
            r_start_off <= c_reset_off;
            r_inflight  <= '0;
            r_drop      <= '0;
            r_of_rd     <= '0;
            r_of_wr     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            if (redirect_val) begin
                r_pc        <= redirect_pc & c_align_mask;
                r_start_off <= w_redir_off;
            end else if (w_req_fire) begin
                r_pc        <= r_pc + ADDR_W'(c_grp_bytes);
                r_start_off <= '0;
            end

            if (w_req_fire) begin
                r_of_wr <= w_of_wr_nxt;
            end
            if (w_resp) begin
                r_of_rd <= w_of_rd_nxt;
            end
            r_inflight <= r_inflight + c_inf_w'(w_req_fire) - c_inf_w'(w_resp);

            // No request issues during a redirect, so what remains outstanding
            // is the current count less any response consumed right now.
            if (redirect_val) begin
                r_drop <= r_inflight - c_inf_w'(w_resp);
            end else if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - c_inf_w'(1);
            end

            if (redirect_val) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                r_count <= r_count + (w_enq ? w_enq_n : '0) - (w_deq ? w_deq_n : '0);
                if (w_enq) begin
                    r_tail <= r_tail + c_ptr_w'(w_enq_n);
                end
                if (w_deq) begin
                    r_head <= r_head + c_ptr_w'(w_deq_n);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit (a 2-wide instance
//            with a modelled I-cache, and a 4-wide instance for PC wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // 2-wide instance
    logic        a_redirect_val;
    logic [31:0] a_redirect_pc;
    logic        a_req_val;
    logic        a_req_rdy;
    logic [31:0] a_req_addr;
    logic        a_resp_val;
    logic [63:0] a_resp_data;
    logic        a_dec_rdy;
    logic [1:0]  a_dec_val;
    logic [63:0] a_dec_inst;
    logic [63:0] a_dec_pc;

    // 4-wide instance
    logic         b_redirect_val;
    logic [31:0]  b_redirect_pc;
    logic         b_req_val;
    logic         b_req_rdy;
    logic [31:0]  b_req_addr;
    logic         b_resp_val;
    logic [127:0] b_resp_data;
    logic         b_dec_rdy;
    logic [3:0]   b_dec_val;
    logic [127:0] b_dec_inst;
    logic [127:0] b_dec_pc;

    fetch_unit #(
        .FETCH_WIDTH(2), .IQ_DEPTH(8), .MAX_INFLIGHT(2), .ADDR_W(32), .RESET_PC(32'h0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .redirect_val(a_redirect_val), .redirect_pc(a_redirect_pc),
        .icache_req_val(a_req_val), .icache_req_rdy(a_req_rdy), .icache_req_addr(a_req_addr),
        .icache_resp_val(a_resp_val), .icache_resp_data(a_resp_data),
        .dec_rdy(a_dec_rdy), .dec_val(a_dec_val), .dec_inst(a_dec_inst), .dec_pc(a_dec_pc)
    );

    fetch_unit #(
        .FETCH_WIDTH(4), .IQ_DEPTH(8), .MAX_INFLIGHT(2), .ADDR_W(32), .RESET_PC(32'hFFFF_FFF4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .redirect_val(b_redirect_val), .redirect_pc(b_redirect_pc),
        .icache_req_val(b_req_val), .icache_req_rdy(b_req_rdy), .icache_req_addr(b_req_addr),
        .icache_resp_val(b_resp_val), .icache_resp_data(b_resp_data),
        .dec_rdy(b_dec_rdy), .dec_val(b_dec_val), .dec_inst(b_dec_inst), .dec_pc(b_dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // In-order, one-cycle I-cache for instance A; cache_en withholds responses.
    logic [31:0] pend [$];
    logic        cache_en;
    logic        s_acc;
    logic        s_cons;
    logic [31:0] s_addr;

    always begin
        @(negedge clk);
        s_acc  = rst_n && a_req_val && a_req_rdy;
        s_addr = a_req_addr;
        s_cons = a_resp_val;
        @(posedge clk);
        #2;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (s_cons && pend.size() > 0) void'(pend.pop_front());
            if (s_acc) pend.push_back(s_addr);
        end
        a_resp_val  = cache_en && rst_n && (pend.size() > 0);
        a_resp_data = '0;
        if (pend.size() > 0) begin
            for (int k = 0; k < 2; k++) a_resp_data[32*k +: 32] = inst_of(pend[0] + 32'(4 * k));
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0: rst_n just released, first request pending.
    task automatic do_reset;
        next_cycle();
        rst_n          = 1'b0;
        a_redirect_val = 1'b0;
        b_redirect_val = 1'b0;
        b_resp_val     = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b0) begin
            failures++; $display("FAIL reset_req_val: got %b want 0", a_req_val);
        end
        checks++;
        if (a_dec_val !== 2'b00) begin
            failures++; $display("FAIL reset_dec_val: got %b want 00", a_dec_val);
        end
        checks++;
        if (b_dec_val !== 4'b0000) begin
            failures++; $display("FAIL reset_b_dec_val: got %b want 0000", b_dec_val);
        end
    endtask

    task automatic test_stream;
        cache_en  = 1'b1;
        a_dec_rdy = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            checks++;
            if (a_req_val !== 1'b1 || a_req_addr !== 32'(8 * c)) begin
                failures++;
                $display("FAIL stream_req c%0d: got val=%b addr=%h want val=1 addr=%h", c, a_req_val, a_req_addr, 32'(8 * c));
            end
            if (c < 2) begin
                checks++;
                if (a_dec_val !== 2'b00) begin
                    failures++; $display("FAIL stream_idle c%0d: got %b want 00", c, a_dec_val);
                end
            end else begin
                checks++;
                if (a_dec_val !== 2'b11 || a_dec_pc[31:0] !== 32'(8 * (c - 2))
                    || a_dec_pc[63:32] !== 32'(8 * (c - 2) + 4)
                    || a_dec_inst[63:32] !== inst_of(32'(8 * (c - 2) + 4))) begin
                    failures++;
                    $display("FAIL stream_dec c%0d: got val=%b pc=%h inst1=%h want val=11 pc0=%h", c, a_dec_val, a_dec_pc, a_dec_inst[63:32], 32'(8 * (c - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int accepted;
        cache_en  = 1'b1;
        a_dec_rdy = 1'b0;
        do_reset();
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (a_req_val && a_req_rdy) accepted++;
        end
        checks++;
        if (accepted !== 4) begin
            failures++; $display("FAIL bp_groups: got %0d want 4", accepted);
        end
        checks++;
        if (a_req_val !== 1'b0) begin
            failures++; $display("FAIL bp_req_low: got %b want 0", a_req_val);
        end
        checks++;
        if (a_dec_val !== 2'b11 || a_dec_pc !== {32'h4, 32'h0}) begin
            failures++; $display("FAIL bp_head: got val=%b pc=%h want val=11 pc=%h", a_dec_val, a_dec_pc, {32'h4, 32'h0});
        end
        next_cycle();
        a_dec_rdy = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) next_cycle();
            @(negedge clk);
            checks++;
            if (a_dec_val !== 2'b11 || a_dec_pc[31:0] !== 32'(8 * g) || a_dec_inst[31:0] !== inst_of(32'(8 * g))) begin
                failures++;
                $display("FAIL bp_drain g%0d: got val=%b pc0=%h inst0=%h want pc0=%h", g, a_dec_val, a_dec_pc[31:0], a_dec_inst[31:0], 32'(8 * g));
            end
        end
    endtask

    task automatic test_redirect;
        cache_en  = 1'b0;
        a_dec_rdy = 1'b1;
        do_reset();
        next_cycle();
        next_cycle();
        a_redirect_val = 1'b1;
        a_redirect_pc  = 32'h106;
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b0 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL redir_cycle: got req=%b dec=%b want 0/00", a_req_val, a_dec_val);
        end
        next_cycle();
        a_redirect_val = 1'b0;
        cache_en       = 1'b1;
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b0 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL redir_full: got req=%b dec=%b want 0/00", a_req_val, a_dec_val);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b1 || a_req_addr !== 32'h100 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL redir_newreq: got req=%b addr=%h dec=%b want 1/00000100/00", a_req_val, a_req_addr, a_dec_val);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b00) begin
            failures++; $display("FAIL redir_stale: got dec=%b want 00", a_dec_val);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b01 || a_dec_pc[31:0] !== 32'h104 || a_dec_inst[31:0] !== inst_of(32'h104)) begin
            failures++; $display("FAIL redir_first: got val=%b pc0=%h inst0=%h want 01/00000104", a_dec_val, a_dec_pc[31:0], a_dec_inst[31:0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b11 || a_dec_pc !== {32'h10C, 32'h108}) begin
            failures++; $display("FAIL redir_second: got val=%b pc=%h want 11/%h", a_dec_val, a_dec_pc, {32'h10C, 32'h108});
        end
    endtask

    task automatic test_redirect_with_resp;
        cache_en  = 1'b1;
        a_dec_rdy = 1'b1;
        do_reset();
        next_cycle();
        a_redirect_val = 1'b1;
        a_redirect_pc  = 32'h200;
        @(negedge clk);
        checks++;
        if (a_resp_val !== 1'b1 || a_req_val !== 1'b0 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL rresp_cycle: got resp=%b req=%b dec=%b want 1/0/00", a_resp_val, a_req_val, a_dec_val);
        end
        next_cycle();
        a_redirect_val = 1'b0;
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b1 || a_req_addr !== 32'h200 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL rresp_req: got req=%b addr=%h dec=%b want 1/00000200/00", a_req_val, a_req_addr, a_dec_val);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b00) begin
            failures++; $display("FAIL rresp_stale: got dec=%b want 00", a_dec_val);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b11 || a_dec_pc !== {32'h204, 32'h200}) begin
            failures++; $display("FAIL rresp_dec: got val=%b pc=%h want 11/%h", a_dec_val, a_dec_pc, {32'h204, 32'h200});
        end
    endtask

    task automatic test_back_to_back;
        int stale;
        cache_en  = 1'b0;
        a_dec_rdy = 1'b1;
        do_reset();
        next_cycle();
        next_cycle();
        a_redirect_val = 1'b1;
        a_redirect_pc  = 32'h300;
        next_cycle();
        a_redirect_pc  = 32'h400;
        cache_en       = 1'b1;
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b0 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL b2b_second: got req=%b dec=%b want 0/00", a_req_val, a_dec_val);
        end
        next_cycle();
        a_redirect_val = 1'b0;
        @(negedge clk);
        checks++;
        if (a_req_val !== 1'b1 || a_req_addr !== 32'h400 || a_dec_val !== 2'b00) begin
            failures++; $display("FAIL b2b_req: got req=%b addr=%h dec=%b want 1/00000400/00", a_req_val, a_req_addr, a_dec_val);
        end
        stale = 0;
        next_cycle();
        @(negedge clk);
        if (a_dec_val !== 2'b00) stale++;
        if (a_req_val && a_req_addr[31:8] == 24'h3) stale++;
        checks++;
        if (stale !== 0) begin
            failures++; $display("FAIL b2b_stale: got %0d stale events want 0", stale);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b11 || a_dec_pc !== {32'h404, 32'h400}) begin
            failures++; $display("FAIL b2b_dec0: got val=%b pc=%h want 11/%h", a_dec_val, a_dec_pc, {32'h404, 32'h400});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (a_dec_val !== 2'b11 || a_dec_pc !== {32'h40C, 32'h408}) begin
            failures++; $display("FAIL b2b_dec1: got val=%b pc=%h want 11/%h", a_dec_val, a_dec_pc, {32'h40C, 32'h408});
        end
    endtask

    task automatic test_wrap;
        logic [127:0] exp_pc;
        cache_en  = 1'b0;
        b_dec_rdy = 1'b1;
        do_reset();
        @(negedge clk);
        checks++;
        if (b_req_val !== 1'b1 || b_req_addr !== 32'hFFFF_FFF0) begin
            failures++; $display("FAIL wrap_req0: got req=%b addr=%h want 1/fffffff0", b_req_val, b_req_addr);
        end
        next_cycle();
        b_resp_val = 1'b1;
        for (int k = 0; k < 4; k++) b_resp_data[32*k +: 32] = inst_of(32'hFFFF_FFF0 + 32'(4 * k));
        @(negedge clk);
        checks++;
        if (b_req_val !== 1'b1 || b_req_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_req1: got req=%b addr=%h want 1/00000000", b_req_val, b_req_addr);
        end
        next_cycle();
        for (int k = 0; k < 4; k++) b_resp_data[32*k +: 32] = inst_of(32'(4 * k));
        @(negedge clk);
        exp_pc = {32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4};
        checks++;
        if (b_dec_val !== 4'b0111 || b_dec_pc[95:0] !== exp_pc[95:0]
            || b_dec_inst[31:0] !== inst_of(32'hFFFF_FFF4) || b_req_val !== 1'b0) begin
            failures++; $display("FAIL wrap_first: got val=%b pc=%h inst0=%h req=%b want 0111/%h req=0", b_dec_val, b_dec_pc[95:0], b_dec_inst[31:0], b_req_val, exp_pc[95:0]);
        end
        next_cycle();
        b_resp_val = 1'b0;
        @(negedge clk);
        exp_pc = {32'hC, 32'h8, 32'h4, 32'h0};
        checks++;
        if (b_dec_val !== 4'b1111 || b_dec_pc !== exp_pc || b_dec_inst[127:96] !== inst_of(32'hC)) begin
            failures++; $display("FAIL wrap_second: got val=%b pc=%h inst3=%h want 1111/%h", b_dec_val, b_dec_pc, b_dec_inst[127:96], exp_pc);
        end
        checks++;
        if (b_req_val !== 1'b1 || b_req_addr !== 32'h10) begin
            failures++; $display("FAIL wrap_req2: got req=%b addr=%h want 1/00000010", b_req_val, b_req_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        cache_en       = 1'b0;
        a_redirect_val = 1'b0;
        a_redirect_pc  = '0;
        a_req_rdy      = 1'b1;
        a_dec_rdy      = 1'b1;
        b_redirect_val = 1'b0;
        b_redirect_pc  = '0;
        b_req_rdy      = 1'b1;
        b_resp_val     = 1'b0;
        b_resp_data    = '0;
        b_dec_rdy      = 1'b1;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_with_resp();
        test_back_to_back();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
